// File: rtl/accel_axis_scheduler.sv
// accel_axis_scheduler
// Shares one 8-bit G_DATA display path between the X, Y and Z accelerometer
// axes. Each axis sample is latched as it arrives. The shown axis is picked
// either by round-robin with a fixed dwell time or by manual select. Samples
// that are overwritten before being shown raise sticky overrun flags.
//
// Input timing: each *_VALID is a one-cycle pulse and the matching *_DATA is
// only meaningful on that cycle. There is no backpressure. A sample is always
// accepted, even while HOLD is high.

module accel_axis_scheduler #(
    parameter int DWELL = 25_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_x_data,
    input  logic [7:0] i_y_data,
    input  logic [7:0] i_z_data,
    input  logic       i_x_valid,
    input  logic       i_y_valid,
    input  logic       i_z_valid,
    input  logic       i_auto,
    input  logic [1:0] i_sel,
    input  logic       i_hold,
    input  logic       i_clr_ovr,
    output logic [7:0] o_g_data,
    output logic [1:0] o_axis,
    output logic       o_strobe,
    output logic [2:0] o_ovr,
    output logic       o_state
);

    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Registered state
    state_t        r_state;
    logic [1:0]    r_axis;
    logic [7:0]    r_g_data;
    logic          r_strobe;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_x_hold;
    logic [7:0]    r_y_hold;
    logic [7:0]    r_z_hold;
    logic [2:0]    r_have;
    logic [2:0]    r_fresh;
    logic [2:0]    r_ovr;

    // Combinational helpers
    logic [2:0] w_valid;
    logic [2:0] w_axis_onehot;
    logic [7:0] w_cur_data;
    logic       w_cur_fresh;
    logic       w_load;
    logic [2:0] w_consume;
    logic [2:0] w_ovr_set;
    logic [1:0] w_first_axis;
    logic [1:0] w_auto_axis;
    logic [1:0] w_man_axis;

    assign w_valid = {i_z_valid, i_y_valid, i_x_valid};

    // The display is refreshed every SHOW cycle that is not frozen by HOLD.
    assign w_load = (r_state == ST_SHOW) && !i_hold;

    // Decode the current axis into a mask and pick its holding register.
    always_comb begin
        w_axis_onehot = 3'b000;
        w_cur_data    = 8'h00;
        case (r_axis)
            2'd0: begin
                w_axis_onehot = 3'b001;
                w_cur_data    = r_x_hold;
            end
            2'd1: begin
                w_axis_onehot = 3'b010;
                w_cur_data    = r_y_hold;
            end
            2'd2: begin
                w_axis_onehot = 3'b100;
                w_cur_data    = r_z_hold;
            end
            default: begin
                w_axis_onehot = 3'b000;
                w_cur_data    = 8'h00;
            end
        endcase
    end

    assign w_cur_fresh = |(r_fresh & w_axis_onehot);

    // A fresh bit is consumed only by a real display load of that axis.
    assign w_consume = w_load ? (r_fresh & w_axis_onehot) : 3'b000;

    // Overrun: a new sample lands on a still-unshown one that is not being
    // shown this very cycle.
    assign w_ovr_set = w_valid & r_fresh & ~w_consume;

    // First axis to show after EMPTY: X beats Y beats Z.
    always_comb begin
        w_first_axis = 2'd0;
        if (i_x_valid) begin
            w_first_axis = 2'd0;
        end else if (i_y_valid) begin
            w_first_axis = 2'd1;
        end else if (i_z_valid) begin
            w_first_axis = 2'd2;
        end
    end

    // Round-robin successor X->Y->Z->X, skipping axes never captured.
    always_comb begin
        w_auto_axis = r_axis;
        case (r_axis)
            2'd0: begin
                if (r_have[1]) begin
                    w_auto_axis = 2'd1;
                end else if (r_have[2]) begin
                    w_auto_axis = 2'd2;
                end
            end
            2'd1: begin
                if (r_have[2]) begin
                    w_auto_axis = 2'd2;
                end else if (r_have[0]) begin
                    w_auto_axis = 2'd0;
                end
            end
            2'd2: begin
                if (r_have[0]) begin
                    w_auto_axis = 2'd0;
                end else if (r_have[1]) begin
                    w_auto_axis = 2'd1;
                end
            end
            default: w_auto_axis = r_axis;
        endcase
    end

    // Manual select: only switch to an axis that has ever been captured.
    always_comb begin
        w_man_axis = r_axis;
        case (i_sel)
            2'd0: if (r_have[0]) w_man_axis = 2'd0;
            2'd1: if (r_have[1]) w_man_axis = 2'd1;
            2'd2: if (r_have[2]) w_man_axis = 2'd2;
            default: w_man_axis = r_axis;
        endcase
    end

    // Capture incoming samples and track have/fresh bits; runs in every state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x_hold <= 8'h00;
            r_y_hold <= 8'h00;
            r_z_hold <= 8'h00;
            r_have   <= 3'b000;
            r_fresh  <= 3'b000;
        end else begin
            if (i_x_valid) r_x_hold <= i_x_data;
            if (i_y_valid) r_y_hold <= i_y_data;
            if (i_z_valid) r_z_hold <= i_z_data;
            r_have  <= r_have | w_valid;
            // A new sample re-arms fresh even if the old one is consumed now.
            r_fresh <= (r_fresh & ~w_consume) | w_valid;
        end
    end

    // Sticky overrun flags; a set in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovr <= 3'b000;
        end else begin
            r_ovr <= (i_clr_ovr ? 3'b000 : r_ovr) | w_ovr_set;
        end
    end

    // Display FSM: axis selection, dwell counting, G_DATA load and STROBE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_EMPTY;
            r_axis   <= 2'd0;
            r_g_data <= 8'h00;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_strobe <= 1'b0;
                    if (|w_valid) begin
                        r_state <= ST_SHOW;
                        r_axis  <= w_first_axis;
                    end
                end
                ST_SHOW: begin
                    if (i_hold) begin
                        // Everything visible is frozen; captures continue.
                        r_strobe <= 1'b0;
                    end else begin
                        // Load uses the pre-update axis, so a new axis shows
                        // up on G_DATA one cycle after AXIS changes.
                        r_g_data <= w_cur_data;
                        r_strobe <= w_cur_fresh;
                        if (i_auto) begin
                            if (r_cnt == CNT_LAST) begin
                                r_cnt  <= '0;
                                r_axis <= w_auto_axis;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt  <= '0;
                            r_axis <= w_man_axis;
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign o_g_data = r_g_data;
    assign o_axis   = r_axis;
    assign o_strobe = r_strobe;
    assign o_ovr    = r_ovr;
    assign o_state  = r_state;

endmodule

// File: tb/tb_accel_axis_scheduler.sv
// Directed bench for accel_axis_scheduler with DWELL=4.
module tb_accel_axis_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] x_data;
    logic [7:0] y_data;
    logic [7:0] z_data;
    logic       x_valid;
    logic       y_valid;
    logic       z_valid;
    logic       auto_m;
    logic [1:0] sel;
    logic       hold;
    logic       clr_ovr;
    logic [7:0] g_data;
    logic [1:0] axis;
    logic       strobe;
    logic [2:0] ovr;
    logic       state;

    int checks = 0;
    int errors = 0;

    accel_axis_scheduler #(.DWELL(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_x_data  (x_data),
        .i_y_data  (y_data),
        .i_z_data  (z_data),
        .i_x_valid (x_valid),
        .i_y_valid (y_valid),
        .i_z_valid (z_valid),
        .i_auto    (auto_m),
        .i_sel     (sel),
        .i_hold    (hold),
        .i_clr_ovr (clr_ovr),
        .o_g_data  (g_data),
        .o_axis    (axis),
        .o_strobe  (strobe),
        .o_ovr     (ovr),
        .o_state   (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; x_data = 8'h00; y_data = 8'h00; z_data = 8'h00;
        x_valid = 1'b0; y_valid = 1'b0; z_valid = 1'b0;
        auto_m = 1'b0; sel = 2'd3; hold = 1'b0; clr_ovr = 1'b0;
        #2;

        // ---- Reset with VALIDs pulsing ----
        rst = 1'b1;
        x_valid = 1'b1; y_valid = 1'b1; z_valid = 1'b1;
        x_data = 8'hFF; y_data = 8'hFE; z_data = 8'hFD;
        tick();
        tick();
        rst = 1'b0;
        x_valid = 1'b0; y_valid = 1'b0; z_valid = 1'b0;
        chk("rst_g", g_data, 8'h00);
        chk("rst_axis", {6'd0, axis}, 8'd0);
        chk("rst_ovr", {5'd0, ovr}, 8'd0);
        chk("rst_strobe", {7'd0, strobe}, 8'd0);
        chk("rst_state", {7'd0, state}, 8'd0);
        tick();
        chk("rst_idle_state", {7'd0, state}, 8'd0);
        chk("rst_idle_g", g_data, 8'h00);

        // ---- First capture: Y then X ----
        y_valid = 1'b1; y_data = 8'h2A;
        tick();
        chk("fc_state", {7'd0, state}, 8'd1);
        chk("fc_axis_e0", {6'd0, axis}, 8'd1);
        chk("fc_g_e0", g_data, 8'h00);
        y_valid = 1'b0; x_valid = 1'b1; x_data = 8'h11;
        tick();
        x_valid = 1'b0;
        chk("fc_g_e1", g_data, 8'h2A);
        chk("fc_strobe_e1", {7'd0, strobe}, 8'd1);
        chk("fc_axis_e1", {6'd0, axis}, 8'd1);
        tick();
        chk("fc_strobe_e2", {7'd0, strobe}, 8'd0);
        chk("fc_g_e2", g_data, 8'h2A);
        chk("fc_axis_e2", {6'd0, axis}, 8'd1);

        // ---- Auto round-robin over X, Y, Z ----
        do_reset();
        x_valid = 1'b1; y_valid = 1'b1; z_valid = 1'b1;
        x_data = 8'h10; y_data = 8'hF0; z_data = 8'h7F;
        tick();
        x_valid = 1'b0; y_valid = 1'b0; z_valid = 1'b0;
        chk("rr_axis_e0", {6'd0, axis}, 8'd0);
        auto_m = 1'b1;
        begin
            logic [1:0] exp_axis [1:13];
            logic [7:0] exp_g    [1:13];
            logic       exp_stb  [1:13];
            exp_axis = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                         2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
            exp_g    = '{8'h10, 8'h10, 8'h10, 8'h10, 8'hF0, 8'hF0, 8'hF0,
                         8'hF0, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h10};
            exp_stb  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            for (int k = 1; k <= 13; k++) begin
                tick();
                chk($sformatf("rr_axis_e%0d", k), {6'd0, axis}, {6'd0, exp_axis[k]});
                chk($sformatf("rr_g_e%0d", k), g_data, exp_g[k]);
                chk($sformatf("rr_strobe_e%0d", k), {7'd0, strobe}, {7'd0, exp_stb[k]});
            end
        end

        // ---- Skip the never-captured Y axis ----
        auto_m = 1'b0;
        do_reset();
        x_valid = 1'b1; z_valid = 1'b1;
        x_data = 8'h21; z_data = 8'h43;
        tick();
        x_valid = 1'b0; z_valid = 1'b0;
        chk("skip_axis_e0", {6'd0, axis}, 8'd0);
        auto_m = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("skip_axis_e%0d", k), {6'd0, axis},
                (((k >> 2) & 1) != 0) ? 8'd2 : 8'd0);
        end
        chk("skip_g_z", g_data, 8'h43);

        // ---- Manual select and HOLD ----
        auto_m = 1'b0;
        do_reset();
        x_valid = 1'b1; y_valid = 1'b1; z_valid = 1'b1;
        x_data = 8'h01; y_data = 8'h02; z_data = 8'h03;
        tick();
        x_valid = 1'b0; y_valid = 1'b0; z_valid = 1'b0;
        tick();
        chk("man_g_x", g_data, 8'h01);
        sel = 2'd2;
        tick();
        chk("man_axis_sel2", {6'd0, axis}, 8'd2);
        sel = 2'd3;
        tick();
        chk("man_axis_sel3", {6'd0, axis}, 8'd2);
        chk("man_g_z", g_data, 8'h03);
        chk("man_strobe_z", {7'd0, strobe}, 8'd1);
        tick();
        hold = 1'b1; z_valid = 1'b1; z_data = 8'h55;
        tick();
        z_valid = 1'b0;
        chk("hold_g", g_data, 8'h03);
        chk("hold_strobe", {7'd0, strobe}, 8'd0);
        tick();
        chk("hold_g2", g_data, 8'h03);
        chk("hold_strobe2", {7'd0, strobe}, 8'd0);
        hold = 1'b0;
        tick();
        chk("release_g", g_data, 8'h55);
        chk("release_strobe", {7'd0, strobe}, 8'd1);
        chk("release_ovr", {5'd0, ovr}, 8'd0);

        // ---- Mid-operation reset, simultaneous VALID+consume, overrun ----
        do_reset();
        chk("mid_rst_g", g_data, 8'h00);
        chk("mid_rst_axis", {6'd0, axis}, 8'd0);
        chk("mid_rst_state", {7'd0, state}, 8'd0);
        x_valid = 1'b1; x_data = 8'h01;
        tick();
        x_data = 8'h77;
        tick();
        x_valid = 1'b0;
        chk("sim_g_old", g_data, 8'h01);
        chk("sim_strobe1", {7'd0, strobe}, 8'd1);
        chk("sim_ovr", {5'd0, ovr}, 8'd0);
        tick();
        chk("sim_g_new", g_data, 8'h77);
        chk("sim_strobe2", {7'd0, strobe}, 8'd1);
        tick();
        chk("sim_strobe3", {7'd0, strobe}, 8'd0);
        hold = 1'b1;
        y_valid = 1'b1; y_data = 8'h66;
        tick();
        chk("ovr_first_y", {5'd0, ovr}, 8'h00);
        y_data = 8'h67;
        tick();
        chk("ovr_second_y", {5'd0, ovr}, 8'h02);
        y_data = 8'h68; clr_ovr = 1'b1;
        tick();
        chk("ovr_set_wins", {5'd0, ovr}, 8'h02);
        y_valid = 1'b0;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared", {5'd0, ovr}, 8'h00);
        chk("ovr_hold_g", g_data, 8'h77);
        hold = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
